// File: rtl/io_write_buffer_pkg.sv
// Shared constants and types for the UART write buffer between the CPU port and the RAM/UART bus.
package io_write_buffer_pkg;

  localparam int          ADDR_LEN     = 32;
  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [31:0] UART_TX_ADDR = 32'h0003_0000;
  localparam logic [31:0] STOP_ADDR    = 32'h0003_0004;

  // What the bus does with this cycle; one value per priority outcome.
  typedef enum logic [2:0] {
    ACT_IDLE,   // no CPU access, no drain
    ACT_HOLD,   // reset or rdy low: bus quiet, nothing moves
    ACT_DRAIN,  // replay FIFO head to the UART
    ACT_PASS,   // CPU access goes straight to the bus
    ACT_PUSH,   // CPU UART byte absorbed into the FIFO
    ACT_STALL   // CPU access cannot be taken this cycle
  } act_t;

  // IO region select from address bits 17:16.
  function automatic logic is_io(input logic [1:0] sel);
    return sel == IO_SEL;
  endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// DEPTH x 8 synchronous byte FIFO; pointers wrap naturally because DEPTH is a power of two.
module io_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = count == (PTR_W+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_write_buffer.sv
// Buffers CPU byte writes to the UART while its TX buffer is full and replays them in order;
// all other CPU traffic passes through. Everything outside the FIFO is combinational.
module io_write_buffer
  import io_write_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                cpu_en,
  input  logic                cpu_wr,
  input  logic [ADDR_LEN-1:0] cpu_a,
  input  logic [7:0]          cpu_dout,
  output logic [7:0]          cpu_din,
  output logic                cpu_stall,
  input  logic                io_buffer_full,
  output logic [ADDR_LEN-1:0] ram_a,
  output logic [7:0]          ram_dout,
  output logic                ram_wr,
  input  logic [7:0]          ram_din
);

  logic           is_tx, is_stop;
  logic           push, pop;
  logic [7:0]     head;
  logic [PTR_W:0] count;
  logic           fifo_full, fifo_empty;
  act_t           act;

  assign is_tx   = is_io(cpu_a[17:16]) & ~cpu_a[2];
  assign is_stop = is_io(cpu_a[17:16]) &  cpu_a[2];
  assign cpu_din = ram_din;

  io_byte_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (cpu_dout),
    .head  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Priority decode: draining wins, so push and pop never coincide.
  always_comb begin
    act = ACT_IDLE;
    if (!rst_n || !rdy) begin
      act = ACT_HOLD;
    end else if (!fifo_empty && !io_buffer_full) begin
      act = ACT_DRAIN;
    end else if (cpu_en) begin
      if (cpu_wr && is_tx) begin
        // Reaching here with bytes pending means the UART is full, so buffer.
        if (fifo_empty && !io_buffer_full) act = ACT_PASS;
        else if (!fifo_full)               act = ACT_PUSH;
        else                               act = ACT_STALL;
      end else if (cpu_wr && is_stop) begin
        // The end marker must never overtake bytes still waiting in the FIFO.
        act = (count == '0) ? ACT_PASS : ACT_STALL;
      end else begin
        act = ACT_PASS;
      end
    end
  end

  // Bus and FIFO controls for the chosen action.
  always_comb begin
    ram_a     = cpu_a;
    ram_dout  = cpu_dout;
    ram_wr    = 1'b0;
    cpu_stall = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (act)
      ACT_HOLD: begin
        if (!rst_n) begin
          ram_a    = '0;
          ram_dout = '0;
        end
      end
      ACT_DRAIN: begin
        ram_a     = UART_TX_ADDR;
        ram_dout  = head;
        ram_wr    = 1'b1;
        pop       = 1'b1;
        cpu_stall = cpu_en;
      end
      ACT_PASS:  ram_wr    = cpu_wr;
      ACT_PUSH:  push      = 1'b1;
      ACT_STALL: cpu_stall = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_io_write_buffer.sv
// Self-checking bench for io_write_buffer: stateless vector table, directed corner sequences,
// then random traffic against a queue-based reference model with an output-order scoreboard.
module tb_io_write_buffer;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam logic [31:0] TX   = 32'h30000;
  localparam logic [31:0] STOP = 32'h30004;

  logic        clk = 1'b0;
  logic        rst_n, rdy, cpu_en, cpu_wr, io_buffer_full;
  logic [31:0] cpu_a, ram_a;
  logic [7:0]  cpu_dout, cpu_din, ram_dout, ram_din;
  logic        cpu_stall, ram_wr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  io_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .cpu_en(cpu_en), .cpu_wr(cpu_wr), .cpu_a(cpu_a),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_stall(cpu_stall),
    .io_buffer_full(io_buffer_full), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr),
    .ram_din(ram_din)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic wr, input logic [31:0] a, input logic [7:0] d);
    cpu_en = en; cpu_wr = wr; cpu_a = a; cpu_dout = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] fifo_count();
    return 32'(dut.u_fifo.count);
  endfunction

  // Absorb n bytes (base, base+1, ...) while the UART reports full.
  task automatic fill(input int n, input logic [7:0] base);
    io_buffer_full = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, TX, base + 8'(i));
      @(negedge clk);
      chk("fill_wr", 32'(ram_wr), 0);
      chk("fill_stall", 32'(cpu_stall), 0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 8'h0);
  endtask

  typedef struct {
    logic        en, wr, full;
    logic [31:0] a;
    logic [7:0]  d;
    logic        e_wr, e_stall;
    logic [31:0] e_a;
    logic [7:0]  e_d;
  } vec_t;

  vec_t vt[8];

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] exp_stream[$];
  logic [7:0] got_stream[$];

  initial begin
    rst_n = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; ram_din = 8'h0;
    drive(1'b1, 1'b1, TX, 8'h77);
    #12;
    chk("rst_wr", 32'(ram_wr), 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_a", ram_a, 0);
    chk("rst_dout", 32'(ram_dout), 0);
    chk("rst_count", fifo_count(), 0);
    drive(1'b0, 1'b0, 32'h0, 8'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Single-cycle vectors with an empty FIFO; none of them pushes.
    vt[0] = '{1, 1, 0, TX,             8'h41, 1, 0, TX,             8'h41};
    vt[1] = '{1, 1, 0, TX,             8'h00, 1, 0, TX,             8'h00};
    vt[2] = '{1, 1, 1, STOP,           8'h00, 1, 0, STOP,           8'h00};
    vt[3] = '{1, 0, 0, 32'h0000_0100,  8'h00, 0, 0, 32'h0000_0100,  8'h00};
    vt[4] = '{1, 1, 1, 32'h0000_0200,  8'h77, 1, 0, 32'h0000_0200,  8'h77};
    vt[5] = '{0, 0, 1, 32'h0001_2345,  8'h00, 0, 0, 32'h0001_2345,  8'h00};
    vt[6] = '{1, 0, 1, TX,             8'h00, 0, 0, TX,             8'h00};
    vt[7] = '{1, 1, 1, 32'h0001_0004,  8'h5C, 1, 0, 32'h0001_0004,  8'h5C};
    for (int i = 0; i < 8; i++) begin
      io_buffer_full = vt[i].full;
      drive(vt[i].en, vt[i].wr, vt[i].a, vt[i].d);
      @(negedge clk);
      chk("vec_wr", 32'(ram_wr), 32'(vt[i].e_wr));
      chk("vec_stall", 32'(cpu_stall), 32'(vt[i].e_stall));
      chk("vec_a", ram_a, vt[i].e_a);
      if (vt[i].e_wr) chk("vec_dout", 32'(ram_dout), 32'(vt[i].e_d));
      tick();
      chk("vec_count", fifo_count(), 0);
    end
    io_buffer_full = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 8'h0);

    // Buffer then drain three bytes with no CPU access.
    fill(3, 8'h41);
    chk("buf_count", fifo_count(), 3);
    io_buffer_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_wr", 32'(ram_wr), 1);
      chk("drain_a", ram_a, TX);
      chk("drain_dout", 32'(ram_dout), 32'(8'h41 + 8'(i)));
      tick();
    end
    @(negedge clk);
    chk("drain_done_wr", 32'(ram_wr), 0);
    tick();

    // Overflow: the DEPTH+1th byte waits until exactly one slot frees.
    fill(DEPTH, 8'h00);
    drive(1'b1, 1'b1, TX, 8'(DEPTH));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ovf_stall", 32'(cpu_stall), 1);
      chk("ovf_wr", 32'(ram_wr), 0);
      tick();
    end
    io_buffer_full = 1'b0;
    @(negedge clk);
    chk("ovf_drain_stall", 32'(cpu_stall), 1);
    chk("ovf_drain_dout", 32'(ram_dout), 0);
    tick();
    io_buffer_full = 1'b1;
    @(negedge clk);
    chk("ovf_push_stall", 32'(cpu_stall), 0);
    chk("ovf_push_wr", 32'(ram_wr), 0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 8'h0);
    chk("ovf_count", fifo_count(), DEPTH);
    io_buffer_full = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      chk("ovf_order_wr", 32'(ram_wr), 1);
      chk("ovf_order", 32'(ram_dout), i);
      tick();
    end
    chk("ovf_empty", fifo_count(), 0);

    // Stop marker held behind two pending bytes.
    fill(2, 8'hA0);
    drive(1'b1, 1'b1, STOP, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stop_hold", 32'(cpu_stall), 1);
      chk("stop_hold_wr", 32'(ram_wr), 0);
      tick();
    end
    io_buffer_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stop_drain_stall", 32'(cpu_stall), 1);
      chk("stop_drain_a", ram_a, TX);
      chk("stop_drain_dout", 32'(ram_dout), 32'(8'hA0 + 8'(i)));
      tick();
    end
    @(negedge clk);
    chk("stop_issue_stall", 32'(cpu_stall), 0);
    chk("stop_issue_wr", 32'(ram_wr), 1);
    chk("stop_issue_a", ram_a, STOP);
    tick();
    drive(1'b0, 1'b0, 32'h0, 8'h0);

    // RAM read colliding with a drain, then read data return.
    fill(1, 8'h99);
    io_buffer_full = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0100, 8'h00);
    @(negedge clk);
    chk("rd_drain_stall", 32'(cpu_stall), 1);
    chk("rd_drain_dout", 32'(ram_dout), 32'h99);
    tick();
    @(negedge clk);
    chk("rd_issue_stall", 32'(cpu_stall), 0);
    chk("rd_issue_a", ram_a, 32'h100);
    chk("rd_issue_wr", 32'(ram_wr), 0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 8'h0);
    ram_din = 8'h5A;
    #1 chk("rd_din", 32'(cpu_din), 32'h5A);

    // rdy low freezes a pending drain.
    fill(1, 8'h55);
    io_buffer_full = 1'b0;
    rdy = 1'b0;
    drive(1'b1, 1'b1, TX, 8'h66);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("frz_wr", 32'(ram_wr), 0);
      chk("frz_stall", 32'(cpu_stall), 0);
      tick();
      chk("frz_count", fifo_count(), 1);
    end
    rdy = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 8'h0);
    @(negedge clk);
    chk("frz_rel_wr", 32'(ram_wr), 1);
    chk("frz_rel_dout", 32'(ram_dout), 32'h55);
    tick();
    chk("frz_rel_count", fifo_count(), 0);

    // Asynchronous reset while a drain is in progress.
    fill(2, 8'hB0);
    io_buffer_full = 1'b0;
    #2 chk("rst_mid_pre", 32'(ram_wr), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr", 32'(ram_wr), 0);
    chk("rst_mid_stall", 32'(cpu_stall), 0);
    chk("rst_mid_a", ram_a, 0);
    chk("rst_mid_count", fifo_count(), 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_after_wr", 32'(ram_wr), 0);
    tick();

    // Random traffic against the queue model; a stalled request is held like a real CPU.
    begin
      logic hold = 1'b0;
      q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic        e_wr, e_stall, dpush, dpop, acc, tx, stop;
        logic [31:0] e_a;
        logic [7:0]  e_d;
        rdy = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 7) == 0) io_buffer_full = ~io_buffer_full;
        if (!hold) begin
          logic [31:0] a;
          case ($urandom_range(0, 4))
            0: a = TX;
            1: a = STOP;
            2: a = 32'h30008;
            3: a = 32'h100;
            default: a = {14'h0, 18'($urandom)};
          endcase
          drive($urandom_range(0, 9) < 7, $urandom_range(0, 2) != 0, a, 8'($urandom));
        end
        @(negedge clk);
        tx   = (cpu_a[17:16] == 2'b11) && !cpu_a[2];
        stop = (cpu_a[17:16] == 2'b11) &&  cpu_a[2];
        e_wr = 0; e_stall = 0; e_a = cpu_a; e_d = cpu_dout; dpush = 0; dpop = 0; acc = 0;
        if (!rdy) begin
        end else if (q.size() > 0 && !io_buffer_full) begin
          e_wr = 1; e_a = TX; e_d = q[0]; e_stall = cpu_en; dpop = 1;
        end else if (cpu_en && cpu_wr && tx) begin
          if (q.size() == 0 && !io_buffer_full) begin e_wr = 1; acc = 1; end
          else if (q.size() < DEPTH)            begin dpush = 1; acc = 1; end
          else                                  e_stall = 1;
        end else if (cpu_en && cpu_wr && stop) begin
          if (q.size() == 0) e_wr = 1; else e_stall = 1;
        end else if (cpu_en) begin
          e_wr = cpu_wr;
        end
        chk("rnd_wr", 32'(ram_wr), 32'(e_wr));
        chk("rnd_stall", 32'(cpu_stall), 32'(e_stall));
        chk("rnd_count", fifo_count(), q.size());
        if (e_wr || (rdy && !cpu_en)) chk("rnd_a", ram_a, e_a);
        if (e_wr) chk("rnd_dout", 32'(ram_dout), 32'(e_d));
        if (ram_wr && ram_a[17:16] == 2'b11 && !ram_a[2]) got_stream.push_back(ram_dout);
        if (acc) exp_stream.push_back(cpu_dout);
        if (dpop) void'(q.pop_front());
        if (dpush) q.push_back(cpu_dout);
        hold = cpu_en && (e_stall || !rdy);
        tick();
      end
      // Flush whatever remains and compare the UART byte stream with program order.
      rdy = 1'b1; io_buffer_full = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 8'h0);
      for (int i = 0; i < DEPTH + 2; i++) begin
        @(negedge clk);
        if (ram_wr && ram_a == TX) got_stream.push_back(ram_dout);
        tick();
      end
      chk("rnd_stream_len", got_stream.size(), exp_stream.size());
      for (int i = 0; i < exp_stream.size() && i < got_stream.size(); i++)
        chk("rnd_stream_byte", 32'(got_stream[i]), 32'(exp_stream[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
